// File: rtl/rgb_cmd_pkg.sv
// Shared types and helpers for the RGB command parser: FSM states, channel ids,
// ASCII constants and a hex-digit decoder.
package rgb_cmd_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StHexHi,
    StHexLo,
    StTerm,
    StAck
  } state_e;

  typedef enum logic [1:0] {
    ChRed,
    ChGreen,
    ChBlue
  } chan_e;

  localparam logic [7:0] CharCr   = 8'h0D;
  localparam logic [7:0] CharLf   = 8'h0A;
  localparam logic [7:0] CharRUp  = 8'h52;
  localparam logic [7:0] CharRLo  = 8'h72;
  localparam logic [7:0] CharGUp  = 8'h47;
  localparam logic [7:0] CharGLo  = 8'h67;
  localparam logic [7:0] CharBUp  = 8'h42;
  localparam logic [7:0] CharBLo  = 8'h62;

  typedef struct packed {
    logic       valid;
    logic [3:0] nib;
  } hex_t;

  function automatic hex_t hex_decode(input logic [7:0] c);
    hex_t h;
    h.valid = 1'b1;
    h.nib   = c[3:0];
    if (c >= 8'h30 && c <= 8'h39) begin
      h.nib = c[3:0];
    end else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) begin
      // 'A'/'a' have low nibble 1, so adding 9 yields 10..15
      h.nib = c[3:0] + 4'd9;
    end else begin
      h.valid = 1'b0;
    end
    return h;
  endfunction

  function automatic logic is_term(input logic [7:0] c);
    return (c == CharCr) || (c == CharLf);
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM output: shadow duty register reloaded at period wrap, compare
// against the shared counter, registered active-low pin.
module pwm_channel (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] duty,
  input  logic       load,
  input  logic [7:0] cnt,
  output logic       pin_n
);

  logic [7:0] shadow_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= 8'h00;
      pin_n    <= 1'b1;
    end else begin
      if (load) begin
        shadow_q <= duty;
      end
      pin_n <= !(cnt < shadow_q);
    end
  end

endmodule

// File: rtl/rgb_cmd_pwm.sv
// ASCII command parser driving three 8-bit PWM LED channels.
// Define RGB_CMD_ECHO_EN to transmit an acknowledge byte after each command.
module rgb_cmd_pwm
  import rgb_cmd_pkg::*;
#(
  parameter int unsigned PWM_PRESCALE = 4,
  parameter logic [7:0]  ACK_OK       = 8'h4B,
  parameter logic [7:0]  ACK_ERR      = 8'h3F
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] RX_DATA,
  input  logic       RX_VALID,
  output logic [7:0] TX_DATA,
  output logic       TX_START,
  input  logic       TX_BUSY,
  output logic       RED_N,
  output logic       GREEN_N,
  output logic       BLUE_N
);

  localparam int unsigned PreW = (PWM_PRESCALE > 1) ? $clog2(PWM_PRESCALE) : 1;

  state_e     state_q, state_d;
  chan_e      chan_q, chan_d;
  logic [7:0] pending_q, pending_d;
  logic [7:0] duty_q [3];
  logic [7:0] duty_d [3];
  logic       cmd_ok, cmd_err;
  hex_t       hex;

`ifdef RGB_CMD_ECHO_EN
  logic [7:0] tx_data_q, tx_data_d;
  logic       tx_start_q, tx_start_d;
`endif

  always_comb begin
    state_d   = state_q;
    chan_d    = chan_q;
    pending_d = pending_q;
    duty_d    = duty_q;
    cmd_ok    = 1'b0;
    cmd_err   = 1'b0;
    hex       = hex_decode(RX_DATA);
`ifdef RGB_CMD_ECHO_EN
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (RX_VALID) begin
          case (RX_DATA)
            CharRUp, CharRLo: begin chan_d = ChRed;   state_d = StHexHi; end
            CharGUp, CharGLo: begin chan_d = ChGreen; state_d = StHexHi; end
            CharBUp, CharBLo: begin chan_d = ChBlue;  state_d = StHexHi; end
            // Bare terminators are swallowed so CRLF line endings are harmless
            default: cmd_err = !is_term(RX_DATA);
          endcase
        end
      end
      StHexHi: begin
        if (RX_VALID) begin
          if (hex.valid) begin
            pending_d[7:4] = hex.nib;
            state_d        = StHexLo;
          end else begin
            cmd_err = 1'b1;
          end
        end
      end
      StHexLo: begin
        if (RX_VALID) begin
          if (hex.valid) begin
            pending_d[3:0] = hex.nib;
            state_d        = StTerm;
          end else begin
            cmd_err = 1'b1;
          end
        end
      end
      StTerm: begin
        if (RX_VALID) begin
          if (is_term(RX_DATA)) begin
            case (chan_q)
              ChRed:   duty_d[0] = pending_q;
              ChGreen: duty_d[1] = pending_q;
              default: duty_d[2] = pending_q;
            endcase
            cmd_ok = 1'b1;
          end else begin
            cmd_err = 1'b1;
          end
        end
      end
`ifdef RGB_CMD_ECHO_EN
      StAck: begin
        if (!TX_BUSY) begin
          tx_start_d = 1'b1;
          state_d    = StIdle;
        end
      end
`endif
      default: state_d = StIdle;
    endcase

    if (cmd_ok || cmd_err) begin
`ifdef RGB_CMD_ECHO_EN
      tx_data_d = cmd_ok ? ACK_OK : ACK_ERR;
      state_d   = StAck;
`else
      state_d   = StIdle;
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= StIdle;
      chan_q    <= ChRed;
      pending_q <= 8'h00;
      duty_q    <= '{default: 8'h00};
    end else begin
      state_q   <= state_d;
      chan_q    <= chan_d;
      pending_q <= pending_d;
      duty_q    <= duty_d;
    end
  end

`ifdef RGB_CMD_ECHO_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      tx_data_q  <= 8'h00;
      tx_start_q <= 1'b0;
    end else begin
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
    end
  end

  assign TX_DATA  = tx_data_q;
  assign TX_START = tx_start_q;
`else
  logic unused_tx_busy;
  assign unused_tx_busy = TX_BUSY;
  assign TX_DATA        = 8'h00;
  assign TX_START       = 1'b0;
`endif

  // Shared PWM timebase
  logic [PreW-1:0] pre_q;
  logic [7:0]      cnt_q;
  logic            step, wrap;
  logic [2:0]      pin_n;

  assign step = (pre_q == PreW'(PWM_PRESCALE - 1));
  assign wrap = step && (cnt_q == 8'hFF);

  always_ff @(posedge CLK) begin
    if (RST) begin
      pre_q <= '0;
      cnt_q <= 8'h00;
    end else if (step) begin
      pre_q <= '0;
      cnt_q <= cnt_q + 8'd1;
    end else begin
      pre_q <= pre_q + 1'b1;
    end
  end

  for (genvar c = 0; c < 3; c++) begin : g_chan
    pwm_channel u_pwm (
      .clk   (CLK),
      .rst   (RST),
      .duty  (duty_q[c]),
      .load  (wrap),
      .cnt   (cnt_q),
      .pin_n (pin_n[c])
    );
  end

  assign RED_N   = pin_n[0];
  assign GREEN_N = pin_n[1];
  assign BLUE_N  = pin_n[2];

endmodule

// File: tb/tb_rgb_cmd_pwm.sv
// Bench for rgb_cmd_pwm: cycle-by-cycle comparison against a command/PWM
// reference model, plus table-driven command vectors with duty measurement.
module tb_rgb_cmd_pwm;

  localparam int P      = 4;
  localparam int PERIOD = 256 * P;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] RX_DATA;
  logic       RX_VALID;
  logic [7:0] TX_DATA;
  logic       TX_START;
  logic       TX_BUSY;
  logic       RED_N, GREEN_N, BLUE_N;

  rgb_cmd_pwm #(
    .PWM_PRESCALE (P),
    .ACK_OK       (8'h4B),
    .ACK_ERR      (8'h3F)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .RX_DATA  (RX_DATA),
    .RX_VALID (RX_VALID),
    .TX_DATA  (TX_DATA),
    .TX_START (TX_START),
    .TX_BUSY  (TX_BUSY),
    .RED_N    (RED_N),
    .GREEN_N  (GREEN_N),
    .BLUE_N   (BLUE_N)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state: elapsed clocks since reset, working/shadow duties,
  // collected command bytes and a pending-acknowledge flag.
  longint unsigned t;
  logic [7:0] m_duty [3];
  logic [7:0] m_sh   [3];
  logic [2:0] m_pins;
  logic [7:0] cmdq [$];
  bit         m_pend;
  logic [7:0] m_txd;
  bit         m_txs;

  function automatic bit m_is_term(input logic [7:0] b);
    return b == 8'h0D || b == 8'h0A;
  endfunction

  function automatic int m_chan(input logic [7:0] b);
    if (b == "R" || b == "r") return 0;
    if (b == "G" || b == "g") return 1;
    if (b == "B" || b == "b") return 2;
    return -1;
  endfunction

  function automatic bit m_is_hex(input logic [7:0] b);
    return (b >= "0" && b <= "9") || (b >= "A" && b <= "F") || (b >= "a" && b <= "f");
  endfunction

  function automatic logic [3:0] m_hexval(input logic [7:0] b);
    if (b >= "0" && b <= "9") return 4'(b - "0");
    if (b >= "A" && b <= "F") return 4'(b - "A" + 10);
    return 4'(b - "a" + 10);
  endfunction

  task automatic m_finish(input bit ok);
    cmdq.delete();
`ifdef RGB_CMD_ECHO_EN
    m_pend = 1'b1;
    m_txd  = ok ? 8'h4B : 8'h3F;
`endif
  endtask

  task automatic m_parse(input logic [7:0] b);
    int n = cmdq.size();
    if (n == 0) begin
      if (m_is_term(b)) return;
      if (m_chan(b) >= 0) cmdq.push_back(b);
      else m_finish(1'b0);
    end else if (n < 3) begin
      if (m_is_hex(b)) cmdq.push_back(b);
      else m_finish(1'b0);
    end else begin
      if (m_is_term(b)) begin
        m_duty[m_chan(cmdq[0])] = {m_hexval(cmdq[1]), m_hexval(cmdq[2])};
        m_finish(1'b1);
      end else begin
        m_finish(1'b0);
      end
    end
  endtask

  task automatic model_edge();
    bit fired, drop;
    if (RST) begin
      t = 0;
      for (int c = 0; c < 3; c++) begin m_duty[c] = 0; m_sh[c] = 0; end
      m_pins = 3'b111;
      cmdq.delete();
      m_pend = 0; m_txd = 8'h00; m_txs = 0;
      return;
    end
    for (int c = 0; c < 3; c++) m_pins[c] = ((t / P) % 256) < m_sh[c] ? 1'b0 : 1'b1;
    t++;
    if (t % PERIOD == 0) for (int c = 0; c < 3; c++) m_sh[c] = m_duty[c];
`ifdef RGB_CMD_ECHO_EN
    fired = m_pend && !TX_BUSY;
`else
    fired = 1'b0;
`endif
    drop  = m_pend;
    m_txs = fired;
    if (fired) m_pend = 1'b0;
    if (RX_VALID && !drop) m_parse(RX_DATA);
  endtask

  int         ack_count = 0;
  logic [7:0] last_ack  = 8'h00;

  task automatic tick();
    @(posedge CLK);
    model_edge();
    #1;
    check("outputs{R,G,B,start,data}", {20'h0, RED_N, GREEN_N, BLUE_N, TX_START, TX_DATA},
          {20'h0, m_pins[0], m_pins[1], m_pins[2], m_txs, m_txd});
    if (TX_START === 1'b1) begin
      ack_count++;
      last_ack = TX_DATA;
    end
  endtask

  task automatic send(input logic [7:0] b);
    RX_DATA  = b;
    RX_VALID = 1'b1;
    tick();
    RX_VALID = 1'b0;
    tick();
  endtask

  function automatic logic pin_of(input int ch);
    return ch == 0 ? RED_N : (ch == 1 ? GREEN_N : BLUE_N);
  endfunction

  // Wait for the new duty to reach the shadow, then count on-clocks over one period
  task automatic measure(input int ch, output int lows);
    repeat (PERIOD + 2) tick();
    lows = 0;
    repeat (PERIOD) begin
      tick();
      if (pin_of(ch) === 1'b0) lows++;
    end
  endtask

  typedef struct {
    logic [7:0] b0, b1, b2, b3;
    int         n;
    logic [7:0] ack;   // 0 means no acknowledge expected
    int         ch;
    int         duty;
  } vec_t;

  vec_t vecs [9];

  task automatic set_vec(input int i, input logic [7:0] b0, b1, b2, b3, input int n,
                         input logic [7:0] ack, input int ch, input int duty);
    vecs[i].b0 = b0; vecs[i].b1 = b1; vecs[i].b2 = b2; vecs[i].b3 = b3;
    vecs[i].n = n; vecs[i].ack = ack; vecs[i].ch = ch; vecs[i].duty = duty;
  endtask

  function automatic logic [7:0] rand_hex();
    int v = int'($urandom % 16);
    if (v < 10) return 8'(8'h30 + v);
    return 8'((($urandom % 2) != 0 ? 8'h41 : 8'h61) + v - 10);
  endfunction

  initial begin
    int         lows, a0, echo;
    logic [7:0] bytes [4];
    logic [7:0] letters [6];
    logic [7:0] cr;

`ifdef RGB_CMD_ECHO_EN
    echo = 1;
`else
    echo = 0;
`endif
    cr = 8'h0D;
    letters[0] = "R"; letters[1] = "r"; letters[2] = "G";
    letters[3] = "g"; letters[4] = "B"; letters[5] = "b";

    set_vec(0, "R", "8", "0", 8'h0D, 4, 8'h4B, 0, 128);
    set_vec(1, "g", "f", "F", 8'h0A, 4, 8'h4B, 1, 255);
    set_vec(2, 8'h0D, 0, 0, 0, 1, 8'h00, 1, 255);
    set_vec(3, "B", "Z", 0, 0, 2, 8'h3F, 2, 0);
    set_vec(4, "B", "4", "0", 8'h0D, 4, 8'h4B, 2, 64);
    set_vec(5, "r", "1", "0", 8'h0A, 4, 8'h4B, 0, 16);
    set_vec(6, "G", "0", "0", 8'h0D, 4, 8'h4B, 1, 0);
    set_vec(7, "R", "8", "0", "X", 4, 8'h3F, 0, 16);
    set_vec(8, "x", 0, 0, 0, 1, 8'h3F, 0, 16);

    RST = 1'b1; RX_VALID = 1'b0; RX_DATA = 8'h00; TX_BUSY = 1'b0;
    tick(); tick();
    check("reset_outputs", {RED_N, GREEN_N, BLUE_N, TX_START, TX_DATA}, {4'b1110, 8'h00});
    RST = 1'b0;
    tick();

    foreach (vecs[i]) begin
      a0 = ack_count;
      bytes[0] = vecs[i].b0; bytes[1] = vecs[i].b1;
      bytes[2] = vecs[i].b2; bytes[3] = vecs[i].b3;
      for (int k = 0; k < vecs[i].n; k++) send(bytes[k]);
      repeat (3) tick();
      check($sformatf("vec%0d_ack_count", i), ack_count - a0,
            (echo != 0 && vecs[i].ack != 8'h00) ? 1 : 0);
      if (echo != 0 && vecs[i].ack != 8'h00) check($sformatf("vec%0d_ack_byte", i), last_ack,
                                                   vecs[i].ack);
      measure(vecs[i].ch, lows);
      check($sformatf("vec%0d_on_clocks", i), lows, vecs[i].duty * P);
    end

    // Acknowledge held off by a long busy period; extra strobe meanwhile
    TX_BUSY = 1'b1;
    a0 = ack_count;
    send("R"); send("2"); send("0"); send(cr);
    repeat (200) tick();
    send("x");
    repeat (300) tick();
    check("busy_no_ack_while_busy", ack_count - a0, 0);
    TX_BUSY = 1'b0;
    repeat (2) tick();
    check("busy_ack_after_release", ack_count - a0, echo);
    if (echo != 0) check("busy_ack_byte", last_ack, 8'h4B);
    repeat (10) tick();
    check("busy_extra_byte_dropped", ack_count - a0, echo);

    // Reset in the middle of a command
    a0 = ack_count;
    send("R"); send("4");
    RST = 1'b1;
    tick();
    check("midcmd_reset_outputs", {RED_N, GREEN_N, BLUE_N, TX_START, TX_DATA}, {4'b1110, 8'h00});
    RST = 1'b0;
    send("0"); send(cr);
    repeat (3) tick();
    check("midcmd_reset_ack_count", ack_count - a0, echo);
    measure(0, lows);
    check("midcmd_reset_red_off", lows, 0);

    // Randomized traffic checked cycle by cycle against the model
    for (int k = 0; k < 60; k++) begin
      if (($urandom % 5) != 0) begin
        bytes[0] = letters[$urandom % 6];
        bytes[1] = rand_hex();
        bytes[2] = rand_hex();
        bytes[3] = (($urandom % 2) != 0) ? 8'h0D : 8'h0A;
        if (($urandom % 8) == 0) bytes[$urandom % 4] = 8'($urandom);
      end else begin
        for (int j = 0; j < 4; j++) bytes[j] = 8'($urandom);
      end
      for (int j = 0; j < 4; j++) begin
        TX_BUSY  = ($urandom % 3) == 0;
        RX_DATA  = bytes[j];
        RX_VALID = 1'b1;
        tick();
        RX_VALID = 1'b0;
        repeat ($urandom % 3) tick();
      end
      TX_BUSY = 1'b0;
      repeat ($urandom % 150) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
